// File: rtl/btb_ckpt_ctrl_if.sv
// Handshake and status bundle between the frontend and the BTB checkpoint controller.
// The master side drives requests; the slave side (the controller) drives bank select and status.
interface btb_ckpt_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             flush_i;
    logic             debug_mode_i;
    logic             enter_req_i;
    logic             exit_req_i;
    logic             btb_update_valid_i;
    logic             req_ready_o;
    logic             checkpoint_mode_o;
    logic             flush_bp_o;
    logic             ack_o;
    logic             timeout_o;
    logic [CNT_W-1:0] swap_count_o;
    logic [2:0]       state_o;

    modport master (
        output flush_i, debug_mode_i, enter_req_i, exit_req_i, btb_update_valid_i,
        input  req_ready_o, checkpoint_mode_o, flush_bp_o, ack_o, timeout_o,
               swap_count_o, state_o
    );

    modport slave (
        input  flush_i, debug_mode_i, enter_req_i, exit_req_i, btb_update_valid_i,
        output req_ready_o, checkpoint_mode_o, flush_bp_o, ack_o, timeout_o,
               swap_count_o, state_o
    );
endinterface

// File: rtl/btb_ckpt_ctrl.sv
// Sequences the bank select of the dual-bank BTB: drains in-flight updates before each swap,
// optionally flushes on entry to the checkpoint bank, and forces exit on timeout or debug.
module btb_ckpt_ctrl #(
    parameter int DRAIN_CYCLES    = 2,
    parameter int FLUSH_ON_ENTER  = 1,
    parameter int MAX_CKPT_CYCLES = 1024,
    parameter int CNT_W           = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    btb_ckpt_ctrl_if.slave  io_ckpt
);
    localparam logic [2:0] MODE_A    = 3'd0;
    localparam logic [2:0] DRAIN_IN  = 3'd1;
    localparam logic [2:0] FLUSH_B   = 3'd2;
    localparam logic [2:0] MODE_B    = 3'd3;
    localparam logic [2:0] DRAIN_OUT = 3'd4;

    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int RES_W = (MAX_CKPT_CYCLES < 2) ? 1 : $clog2(MAX_CKPT_CYCLES + 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES);
    localparam logic [RES_W-1:0] RES_LAST =
        RES_W'((MAX_CKPT_CYCLES == 0) ? 0 : MAX_CKPT_CYCLES - 1);

    logic [2:0]       r_state;
    logic             r_ckpt;
    logic             r_ack;
    logic             r_tmo;
    logic [CNT_W-1:0] r_swap_cnt;
    logic [DRN_W-1:0] r_drn_cnt;
    logic [RES_W-1:0] r_res_cnt;

    logic [DRN_W-1:0] w_drn_next;
    logic             w_drain_done;

    function automatic logic [CNT_W-1:0] sat_inc_swap(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [RES_W-1:0] sat_inc_res(input logic [RES_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Any update restarts the quiet window; the swap fires on the edge the count would hit zero.
    assign w_drn_next   = io_ckpt.btb_update_valid_i ? DRN_LOAD : r_drn_cnt - 1'b1;
    assign w_drain_done = ~io_ckpt.btb_update_valid_i && (r_drn_cnt == DRN_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= MODE_A;
            r_ckpt     <= 1'b0;
            r_ack      <= 1'b0;
            r_tmo      <= 1'b0;
            r_swap_cnt <= '0;
            r_drn_cnt  <= '0;
            r_res_cnt  <= '0;
        end else begin
            r_ack <= 1'b0;
            r_tmo <= 1'b0;
            case (r_state)
                MODE_A: begin
                    if (io_ckpt.enter_req_i && !io_ckpt.debug_mode_i) begin
                        r_state   <= DRAIN_IN;
                        r_drn_cnt <= DRN_LOAD;
                    end
                end
                DRAIN_IN: begin
                    r_drn_cnt <= w_drn_next;
                    if (io_ckpt.flush_i || io_ckpt.debug_mode_i) begin
                        r_state <= MODE_A;
                    end else if (w_drain_done) begin
                        r_ckpt <= 1'b1;
                        if (FLUSH_ON_ENTER != 0) begin
                            r_state <= FLUSH_B;
                        end else begin
                            r_state    <= MODE_B;
                            r_ack      <= 1'b1;
                            r_swap_cnt <= sat_inc_swap(r_swap_cnt);
                            r_res_cnt  <= '0;
                        end
                    end
                end
                FLUSH_B: begin
                    r_state    <= MODE_B;
                    r_ack      <= 1'b1;
                    r_swap_cnt <= sat_inc_swap(r_swap_cnt);
                    r_res_cnt  <= '0;
                end
                MODE_B: begin
                    r_res_cnt <= sat_inc_res(r_res_cnt);
                    // A real exit request outranks the timer so timeout_o only flags forced exits.
                    if (io_ckpt.exit_req_i || io_ckpt.debug_mode_i) begin
                        r_state   <= DRAIN_OUT;
                        r_drn_cnt <= DRN_LOAD;
                    end else if ((MAX_CKPT_CYCLES != 0) && (r_res_cnt == RES_LAST)) begin
                        r_state   <= DRAIN_OUT;
                        r_drn_cnt <= DRN_LOAD;
                        r_tmo     <= 1'b1;
                    end
                end
                DRAIN_OUT: begin
                    r_drn_cnt <= w_drn_next;
                    if (w_drain_done) begin
                        r_state    <= MODE_A;
                        r_ckpt     <= 1'b0;
                        r_ack      <= 1'b1;
                        r_swap_cnt <= sat_inc_swap(r_swap_cnt);
                    end
                end
                default: begin
                    r_state <= MODE_A;
                    r_ckpt  <= 1'b0;
                end
            endcase
        end
    end

    assign io_ckpt.state_o           = r_state;
    assign io_ckpt.checkpoint_mode_o = r_ckpt;
    assign io_ckpt.ack_o             = r_ack;
    assign io_ckpt.timeout_o         = r_tmo;
    assign io_ckpt.swap_count_o      = r_swap_cnt;
    assign io_ckpt.req_ready_o       = (r_state == MODE_A) || (r_state == MODE_B);
    assign io_ckpt.flush_bp_o        = io_ckpt.flush_i || (r_state == FLUSH_B);
endmodule

// File: tb/tb_btb_ckpt_ctrl.sv
// Directed bench for btb_ckpt_ctrl: drain, flush, timeout, exit priority, abort and reset cases.
module tb_btb_ckpt_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    btb_ckpt_ctrl_if #(.CNT_W(2)) bif ();

    btb_ckpt_ctrl #(
        .DRAIN_CYCLES(2), .FLUSH_ON_ENTER(1), .MAX_CKPT_CYCLES(8), .CNT_W(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .io_ckpt(bif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bif.state_o !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", bif.state_o); end
        total++; if (bif.checkpoint_mode_o !== 1'b0) begin bad++; $display("FAIL rst_ckpt got=%b want=0", bif.checkpoint_mode_o); end
        total++; if (bif.ack_o !== 1'b0 || bif.timeout_o !== 1'b0) begin bad++; $display("FAIL rst_pulses ack=%b tmo=%b want=0,0", bif.ack_o, bif.timeout_o); end
        total++; if (bif.swap_count_o !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bif.swap_count_o); end
        total++; if (bif.req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bif.req_ready_o); end
        rst = 1'b0;
        bif.flush_i = 1'b1;
        #1;
        total++; if (bif.flush_bp_o !== 1'b1) begin bad++; $display("FAIL flush_pass got=%b want=1", bif.flush_bp_o); end
        bif.flush_i = 1'b0;
        #1;
        total++; if (bif.flush_bp_o !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b want=0", bif.flush_bp_o); end
    endtask

    task automatic test_enter();
        bif.enter_req_i = 1'b1;
        tick();
        bif.enter_req_i = 1'b0;
        total++; if (bif.state_o !== 3'd1 || bif.checkpoint_mode_o !== 1'b0 || bif.req_ready_o !== 1'b0) begin bad++; $display("FAIL enter_drain st=%0d ckpt=%b rdy=%b want=1,0,0", bif.state_o, bif.checkpoint_mode_o, bif.req_ready_o); end
        tick();
        total++; if (bif.state_o !== 3'd1 || bif.flush_bp_o !== 1'b0) begin bad++; $display("FAIL enter_drain2 st=%0d fbp=%b want=1,0", bif.state_o, bif.flush_bp_o); end
        tick();
        total++; if (bif.state_o !== 3'd2 || bif.checkpoint_mode_o !== 1'b1 || bif.flush_bp_o !== 1'b1) begin bad++; $display("FAIL enter_flush st=%0d ckpt=%b fbp=%b want=2,1,1", bif.state_o, bif.checkpoint_mode_o, bif.flush_bp_o); end
        tick();
        total++; if (bif.state_o !== 3'd3 || bif.flush_bp_o !== 1'b0 || bif.ack_o !== 1'b1) begin bad++; $display("FAIL enter_modeb st=%0d fbp=%b ack=%b want=3,0,1", bif.state_o, bif.flush_bp_o, bif.ack_o); end
        total++; if (bif.swap_count_o !== 2'd1 || bif.req_ready_o !== 1'b1) begin bad++; $display("FAIL enter_count cnt=%0d rdy=%b want=1,1", bif.swap_count_o, bif.req_ready_o); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 7; i++) begin
            bif.enter_req_i = (i == 0);
            tick();
            total++; if (bif.state_o !== 3'd3 || bif.timeout_o !== 1'b0) begin bad++; $display("FAIL tmo_resident i=%0d st=%0d tmo=%b want=3,0", i, bif.state_o, bif.timeout_o); end
            if (i == 0) begin
                total++; if (bif.ack_o !== 1'b0) begin bad++; $display("FAIL ack_single got=%b want=0", bif.ack_o); end
            end
        end
        bif.enter_req_i = 1'b0;
        tick();
        total++; if (bif.state_o !== 3'd4 || bif.timeout_o !== 1'b1 || bif.checkpoint_mode_o !== 1'b1) begin bad++; $display("FAIL tmo_fire st=%0d tmo=%b ckpt=%b want=4,1,1", bif.state_o, bif.timeout_o, bif.checkpoint_mode_o); end
        tick();
        total++; if (bif.state_o !== 3'd4 || bif.timeout_o !== 1'b0) begin bad++; $display("FAIL tmo_pulse st=%0d tmo=%b want=4,0", bif.state_o, bif.timeout_o); end
        tick();
        total++; if (bif.state_o !== 3'd0 || bif.checkpoint_mode_o !== 1'b0 || bif.ack_o !== 1'b1 || bif.swap_count_o !== 2'd2) begin bad++; $display("FAIL tmo_exit st=%0d ckpt=%b ack=%b cnt=%0d want=0,0,1,2", bif.state_o, bif.checkpoint_mode_o, bif.ack_o, bif.swap_count_o); end
    endtask

    task automatic test_drain_updates();
        bif.enter_req_i = 1'b1;
        tick();
        bif.enter_req_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bif.btb_update_valid_i = ((i % 2) == 0);
            tick();
            total++; if (bif.state_o !== 3'd1) begin bad++; $display("FAIL drain_hold i=%0d st=%0d want=1", i, bif.state_o); end
        end
        bif.btb_update_valid_i = 1'b0;
        tick();
        total++; if (bif.state_o !== 3'd2) begin bad++; $display("FAIL drain_release st=%0d want=2", bif.state_o); end
        tick();
        total++; if (bif.state_o !== 3'd3 || bif.ack_o !== 1'b1 || bif.swap_count_o !== 2'd3) begin bad++; $display("FAIL drain_modeb st=%0d ack=%b cnt=%0d want=3,1,3", bif.state_o, bif.ack_o, bif.swap_count_o); end
    endtask

    task automatic test_exit_vs_timeout();
        for (int i = 0; i < 7; i++) tick();
        total++; if (bif.state_o !== 3'd3) begin bad++; $display("FAIL race_resident st=%0d want=3", bif.state_o); end
        bif.exit_req_i = 1'b1;
        tick();
        bif.exit_req_i = 1'b0;
        total++; if (bif.state_o !== 3'd4 || bif.timeout_o !== 1'b0) begin bad++; $display("FAIL race_exit st=%0d tmo=%b want=4,0", bif.state_o, bif.timeout_o); end
        bif.flush_i = 1'b1;
        tick();
        total++; if (bif.state_o !== 3'd4 || bif.timeout_o !== 1'b0) begin bad++; $display("FAIL race_noabort st=%0d tmo=%b want=4,0", bif.state_o, bif.timeout_o); end
        tick();
        bif.flush_i = 1'b0;
        total++; if (bif.state_o !== 3'd0 || bif.ack_o !== 1'b1 || bif.swap_count_o !== 2'd3) begin bad++; $display("FAIL race_sat st=%0d ack=%b cnt=%0d want=0,1,3", bif.state_o, bif.ack_o, bif.swap_count_o); end
    endtask

    task automatic test_flush_abort();
        bif.exit_req_i = 1'b1;
        tick();
        bif.exit_req_i = 1'b0;
        total++; if (bif.state_o !== 3'd0) begin bad++; $display("FAIL exit_ignored st=%0d want=0", bif.state_o); end
        bif.debug_mode_i = 1'b1;
        bif.enter_req_i  = 1'b1;
        tick();
        bif.debug_mode_i = 1'b0;
        total++; if (bif.state_o !== 3'd0 || bif.req_ready_o !== 1'b1) begin bad++; $display("FAIL debug_block st=%0d rdy=%b want=0,1", bif.state_o, bif.req_ready_o); end
        tick();
        bif.enter_req_i = 1'b0;
        total++; if (bif.state_o !== 3'd1) begin bad++; $display("FAIL abort_enter st=%0d want=1", bif.state_o); end
        bif.flush_i = 1'b1;
        tick();
        bif.flush_i = 1'b0;
        total++; if (bif.state_o !== 3'd0 || bif.checkpoint_mode_o !== 1'b0 || bif.ack_o !== 1'b0 || bif.swap_count_o !== 2'd3) begin bad++; $display("FAIL abort_flush st=%0d ckpt=%b ack=%b cnt=%0d want=0,0,0,3", bif.state_o, bif.checkpoint_mode_o, bif.ack_o, bif.swap_count_o); end
    endtask

    task automatic test_reset_in_drain_out();
        bif.enter_req_i = 1'b1;
        tick();
        bif.enter_req_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++; if (bif.state_o !== 3'd3) begin bad++; $display("FAIL rst_seq_modeb st=%0d want=3", bif.state_o); end
        bif.debug_mode_i = 1'b1;
        tick();
        total++; if (bif.state_o !== 3'd4) begin bad++; $display("FAIL debug_exit st=%0d want=4", bif.state_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bif.debug_mode_i = 1'b0;
        total++; if (bif.state_o !== 3'd0 || bif.checkpoint_mode_o !== 1'b0 || bif.swap_count_o !== 2'd0) begin bad++; $display("FAIL midrst st=%0d ckpt=%b cnt=%0d want=0,0,0", bif.state_o, bif.checkpoint_mode_o, bif.swap_count_o); end
        total++; if (bif.ack_o !== 1'b0 || bif.req_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ctl ack=%b rdy=%b want=0,1", bif.ack_o, bif.req_ready_o); end
        tick();
        total++; if (bif.state_o !== 3'd0) begin bad++; $display("FAIL postrst st=%0d want=0", bif.state_o); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.flush_i            = 1'b0;
        bif.debug_mode_i       = 1'b0;
        bif.enter_req_i        = 1'b0;
        bif.exit_req_i         = 1'b0;
        bif.btb_update_valid_i = 1'b0;
        test_reset();
        test_enter();
        test_timeout();
        test_drain_updates();
        test_exit_vs_timeout();
        test_flush_abort();
        test_reset_in_drain_out();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
